// File: rtl/bijiao_pkg.sv
// Shared types for the comparator statistics stage.
// State encoding and majority result codes.
package bijiao_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ  = 2'b00;
  localparam logic [1:0] RES_GT  = 2'b01;
  localparam logic [1:0] RES_LT  = 2'b10;
  localparam logic [1:0] RES_TIE = 2'b11;

endpackage

// File: rtl/bijiao_tongji_if.sv
// Handshake and report bundle between comparator,
// statistics stage and display/control logic.
interface bijiao_tongji_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             xgy;
  logic             xsy;
  logic             xey;
  logic             ack;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       result;

  modport master (
    output start, in_valid, xgy, xsy, xey, ack,
    input  busy, done, gt_cnt, lt_cnt,
    input  eq_cnt, err_cnt, result
  );

  modport slave (
    input  start, in_valid, xgy, xsy, xey, ack,
    output busy, done, gt_cnt, lt_cnt,
    output eq_cnt, err_cnt, result
  );
endinterface

// File: rtl/bijiao_decode.sv
// Classifies one comparator flag triple.
// Exactly one output is high for every input.
module bijiao_decode (
  input  logic xgy,
  input  logic xsy,
  input  logic xey,
  output logic is_gt,
  output logic is_lt,
  output logic is_eq,
  output logic is_err
);
  always_comb begin
    is_gt  = 1'b0;
    is_lt  = 1'b0;
    is_eq  = 1'b0;
    is_err = 1'b0;
    unique case ({xgy, xsy, xey})
      3'b100:  is_gt  = 1'b1;
      3'b010:  is_lt  = 1'b1;
      3'b001:  is_eq  = 1'b1;
      default: is_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/bijiao_tongji.sv
// Windowed statistics over comparator results with
// a registered majority verdict held until acknowledged.
module bijiao_tongji
  import bijiao_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN   = 16
) (
  input logic            clk,
  input logic            rst_n,
  bijiao_tongji_if.slave bus
);
  state_t st, st_n;

  logic [CNT_W-1:0] gt, lt, eq, err, smp;
  logic [CNT_W-1:0] gt_n, lt_n, eq_n, err_n;
  logic [1:0]       res;
  logic is_gt, is_lt, is_eq, is_err;
  logic take, last, clr;

  bijiao_decode u_dec (
    .xgy    (bus.xgy),
    .xsy    (bus.xsy),
    .xey    (bus.xey),
    .is_gt  (is_gt),
    .is_lt  (is_lt),
    .is_eq  (is_eq),
    .is_err (is_err)
  );

  function automatic logic [1:0] majority(
    input logic [CNT_W-1:0] g,
    input logic [CNT_W-1:0] l,
    input logic [CNT_W-1:0] e
  );
    if (g > l && g > e)      return RES_GT;
    else if (l > g && l > e) return RES_LT;
    else if (e > g && e > l) return RES_EQ;
    else                     return RES_TIE;
  endfunction

  assign take = (st == COUNT) && bus.in_valid;
  assign last = take && (smp == CNT_W'(WIN - 1));
  assign clr  = bus.start &&
                ((st == IDLE) ||
                 (st == REPORT && bus.ack));

  assign gt_n  = gt  + CNT_W'(is_gt);
  assign lt_n  = lt  + CNT_W'(is_lt);
  assign eq_n  = eq  + CNT_W'(is_eq);
  assign err_n = err + CNT_W'(is_err);

  always_comb begin
    st_n = st;
    case (st)
      IDLE: begin
        if (bus.start) st_n = COUNT;
      end
      COUNT: begin
        if (last) st_n = REPORT;
      end
      REPORT: begin
        if (bus.ack) st_n = bus.start ? COUNT : IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt  <= '0;
      lt  <= '0;
      eq  <= '0;
      err <= '0;
      smp <= '0;
      res <= RES_EQ;
    end else if (clr) begin
      gt  <= '0;
      lt  <= '0;
      eq  <= '0;
      err <= '0;
      smp <= '0;
      res <= RES_EQ;
    end else if (take) begin
      gt  <= gt_n;
      lt  <= lt_n;
      eq  <= eq_n;
      err <= err_n;
      smp <= smp + 1'b1;
      // verdict uses counts that include this last sample
      if (last) res <= majority(gt_n, lt_n, eq_n);
    end
  end

  assign bus.busy    = (st == COUNT);
  assign bus.done    = (st == REPORT);
  assign bus.gt_cnt  = gt;
  assign bus.lt_cnt  = lt;
  assign bus.eq_cnt  = eq;
  assign bus.err_cnt = err;
  assign bus.result  = res;
endmodule

// File: tb/tb_bijiao_tongji.sv
// Scoreboard bench for bijiao_tongji, WIN=4.
// Reports are modelled at stimulus time and popped at done.
module tb_bijiao_tongji;
  localparam int CNT_W = 8;
  localparam int WIN   = 4;

  typedef struct {
    logic [7:0] gt;
    logic [7:0] lt;
    logic [7:0] eq;
    logic [7:0] err;
    logic [1:0] res;
  } rep_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  rep_t sbq[$];
  rep_t last;

  always #5 clk = ~clk;

  bijiao_tongji_if #(.CNT_W(CNT_W)) bus ();

  bijiao_tongji #(.CNT_W(CNT_W), .WIN(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic rep_t model(input logic [11:0] p);
    rep_t r;
    logic [2:0] f;
    r = '{8'd0, 8'd0, 8'd0, 8'd0, 2'b00};
    for (int i = 3; i >= 0; i--) begin
      f = p[i*3 +: 3];
      if (f == 3'b100)      r.gt++;
      else if (f == 3'b010) r.lt++;
      else if (f == 3'b001) r.eq++;
      else                  r.err++;
    end
    if (r.gt > r.lt && r.gt > r.eq)      r.res = 2'b01;
    else if (r.lt > r.gt && r.lt > r.eq) r.res = 2'b10;
    else if (r.eq > r.gt && r.eq > r.lt) r.res = 2'b00;
    else                                 r.res = 2'b11;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] f);
    bus.in_valid = v;
    {bus.xgy, bus.xsy, bus.xey} = f;
    cyc();
    bus.in_valid = 1'b0;
    {bus.xgy, bus.xsy, bus.xey} = 3'b000;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
  endtask

  task automatic check_report(input string nm);
    int n = 0;
    rep_t e;
    while (bus.done !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      $display("FAIL %s_timeout done=%b want 1", nm, bus.done);
      fails++;
      return;
    end
    checks++;
    if (sbq.size() == 0) begin
      $display("FAIL %s_sb_empty size=0 want >0", nm);
      fails++;
      return;
    end
    e = sbq.pop_front();
    last = e;
    checks++;
    if ({bus.gt_cnt, bus.lt_cnt, bus.eq_cnt, bus.err_cnt}
        !== {e.gt, e.lt, e.eq, e.err}) begin
      $display("FAIL %s_counts got gt=%0d lt=%0d eq=%0d err=%0d want %0d %0d %0d %0d",
               nm, bus.gt_cnt, bus.lt_cnt, bus.eq_cnt, bus.err_cnt,
               e.gt, e.lt, e.eq, e.err);
      fails++;
    end
    checks++;
    if (bus.result !== e.res) begin
      $display("FAIL %s_result got %b want %b", nm, bus.result, e.res);
      fails++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL %s_busy got %b want 0", nm, bus.busy);
      fails++;
    end
  endtask

  task automatic check_clear(input string nm, input logic bz);
    checks++;
    if ({bus.busy, bus.done, bus.gt_cnt, bus.lt_cnt,
         bus.eq_cnt, bus.err_cnt, bus.result}
        !== {bz, 1'b0, 34'd0}) begin
      $display("FAIL %s got busy=%b done=%b gt=%0d lt=%0d eq=%0d err=%0d res=%b want busy=%b rest 0",
               nm, bus.busy, bus.done, bus.gt_cnt, bus.lt_cnt,
               bus.eq_cnt, bus.err_cnt, bus.result, bz);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    check_clear("reset_state", 1'b0);
    rst_n = 1'b1;
    cyc();
    do_start();
    drive(1'b1, 3'b100);
    drive(1'b1, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check_clear("reset_mid_count", 1'b0);
    rst_n = 1'b1;
    cyc();
    do_start();
    check_clear("fresh_start", 1'b1);
    sbq.push_back(model(12'b100_100_100_100));
    for (int i = 0; i < 3; i++) drive(1'b1, 3'b100);
    checks++;
    if (bus.done !== 1'b0) begin
      $display("FAIL fresh_early_done got %b want 0", bus.done);
      fails++;
    end
    drive(1'b1, 3'b100);
    check_report("fresh_window");
    do_ack();
  endtask

  task automatic test_basic();
    logic [11:0] p = 12'b100_100_001_010;
    do_start();
    sbq.push_back(model(p));
    for (int i = 3; i >= 0; i--) drive(1'b1, p[i*3 +: 3]);
    checks++;
    if (bus.done !== 1'b1) begin
      $display("FAIL basic_latency done=%b want 1", bus.done);
      fails++;
    end
    check_report("basic");
    do_ack();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      $display("FAIL basic_ack busy/done=%b%b want 00", bus.busy, bus.done);
      fails++;
    end
  endtask

  task automatic test_err_gaps();
    do_start();
    sbq.push_back(model(12'b100_010_111_000));
    drive(1'b1, 3'b100);
    drive(1'b0, 3'b001);
    drive(1'b1, 3'b010);
    drive(1'b0, 3'b100);
    drive(1'b0, 3'b110);
    drive(1'b1, 3'b111);
    drive(1'b0, 3'b010);
    drive(1'b1, 3'b000);
    check_report("err_gaps");
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 3'b100);
      checks++;
      if ({bus.done, bus.busy, bus.gt_cnt, bus.lt_cnt,
           bus.eq_cnt, bus.err_cnt, bus.result}
          !== {2'b10, last.gt, last.lt, last.eq, last.err, last.res}) begin
        $display("FAIL hold_frozen cyc=%0d done=%b gt=%0d err=%0d res=%b want done=1 gt=%0d err=%0d res=%b",
                 i, bus.done, bus.gt_cnt, bus.err_cnt, bus.result,
                 last.gt, last.err, last.res);
        fails++;
      end
    end
    do_ack();
    checks++;
    if ({bus.done, bus.busy, bus.err_cnt, bus.result}
        !== {2'b00, last.err, last.res}) begin
      $display("FAIL hold_idle_retain done=%b busy=%b err=%0d res=%b want 0 0 %0d %b",
               bus.done, bus.busy, bus.err_cnt, bus.result,
               last.err, last.res);
      fails++;
    end
  endtask

  task automatic test_ack_start();
    do_start();
    sbq.push_back(model(12'b010_010_010_010));
    for (int i = 0; i < 4; i++) drive(1'b1, 3'b010);
    check_report("pre_restart");
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check_clear("ack_start_clear", 1'b1);
    sbq.push_back(model(12'b001_001_001_001));
    for (int i = 0; i < 4; i++) drive(1'b1, 3'b001);
    check_report("restart_eq");
    do_ack();
  endtask

  task automatic test_ignore();
    do_ack();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      $display("FAIL idle_ack busy/done=%b%b want 00", bus.busy, bus.done);
      fails++;
    end
    do_start();
    sbq.push_back(model(12'b001_100_010_100));
    drive(1'b1, 3'b001);
    bus.start = 1'b1;
    drive(1'b1, 3'b100);
    drive(1'b0, 3'b000);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.gt_cnt, bus.eq_cnt} !== {1'b1, 8'd1, 8'd1}) begin
      $display("FAIL count_start_ignored busy=%b gt=%0d eq=%0d want 1 1 1",
               bus.busy, bus.gt_cnt, bus.eq_cnt);
      fails++;
    end
    drive(1'b1, 3'b010);
    drive(1'b1, 3'b100);
    check_report("ignore_window");
    do_ack();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.xgy      = 1'b0;
    bus.xsy      = 1'b0;
    bus.xey      = 1'b0;
    bus.ack      = 1'b0;
    last         = '{8'd0, 8'd0, 8'd0, 8'd0, 2'b00};
    test_reset();
    test_basic();
    test_err_gaps();
    test_hold();
    test_ack_start();
    test_ignore();
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL sb_leftover size=%0d want 0", sbq.size());
      fails++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
